// File: rtl/bcd_timer_ctrl.sv
// ============================================================================
// Module   : bcd_timer_ctrl
// Function : command-driven 2-digit BCD up/down counter with prescaler and
//            programmable target (one-shot or auto-reload)
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_timer_ctrl #(
   parameter int PRESCALE = 4
) (
   input  logic       clk,
   input  logic       _rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_data,
   input  logic       mode_down,
   input  logic       auto_reload,
   output logic [7:0] Q,
   output logic [1:0] state_o,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int              c_PW         = $clog2(PRESCALE);
   localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(PRESCALE - 1);

   localparam logic [2:0] c_OP_NOP   = 3'd0;
   localparam logic [2:0] c_OP_LOAD  = 3'd1;
   localparam logic [2:0] c_OP_START = 3'd2;
   localparam logic [2:0] c_OP_STOP  = 3'd3;
   localparam logic [2:0] c_OP_CLEAR = 3'd4;
   localparam logic [2:0] c_OP_SETTG = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t          r_state, w_state;
   logic [3:0]      r_tens, w_tens;
   logic [3:0]      r_units, w_units;
   logic [7:0]      r_preset, w_preset;
   logic [7:0]      r_target, w_target;
   logic [c_PW-1:0] r_presc, w_presc;
   logic            r_ready, w_ready;
   logic            r_done, w_done;
   logic            r_err, w_err;
   logic            r_reload_pend, w_reload_pend;

   logic            w_accept;
   logic            w_tick;
   logic [3:0]      w_cnt_tens, w_cnt_units;
   logic [7:0]      w_tick_q;

   function automatic logic is_bcd(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   assign w_accept = cmd_valid & r_ready;
   assign w_tick   = (r_state == S_RUN) && (r_presc == c_PRESC_LAST);

   // Both digits are resolved combinationally so carry/borrow lands in the same tick.
   always_comb begin
      w_cnt_tens  = r_tens;
      w_cnt_units = r_units;
      if (!mode_down) begin
         if (r_units == 4'd9) begin
            w_cnt_units = 4'd0;
            w_cnt_tens  = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
         end else begin
            w_cnt_units = r_units + 4'd1;
         end
      end else begin
         if (r_units == 4'd0) begin
            w_cnt_units = 4'd9;
            w_cnt_tens  = (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;
         end else begin
            w_cnt_units = r_units - 4'd1;
         end
      end
   end

   assign w_tick_q = r_reload_pend ? r_preset : {w_cnt_tens, w_cnt_units};

   always_comb begin
      w_state       = r_state;
      w_tens        = r_tens;
      w_units       = r_units;
      w_preset      = r_preset;
      w_target      = r_target;
      w_presc       = r_presc;
      w_ready       = ~w_accept;
      w_done        = 1'b0;
      w_err         = 1'b0;
      w_reload_pend = r_reload_pend;

      if (r_state == S_RUN) begin
         w_presc = w_tick ? '0 : r_presc + 1'b1;
      end

      // An accepted command always takes precedence over a coincident tick.
      if (w_accept) begin
         case (cmd_op)
            c_OP_NOP: begin
            end
            c_OP_LOAD: begin
               if (is_bcd(cmd_data)) begin
                  w_tens        = cmd_data[7:4];
                  w_units       = cmd_data[3:0];
                  w_preset      = cmd_data;
                  w_presc       = '0;
                  w_reload_pend = 1'b0;
                  if (r_state == S_DONE) begin
                     w_state = S_IDLE;
                  end
               end else begin
                  w_err = 1'b1;
               end
            end
            c_OP_START: begin
               case (r_state)
                  S_IDLE, S_DONE: begin
                     w_state       = S_RUN;
                     w_presc       = '0;
                     w_reload_pend = 1'b0;
                  end
                  S_PAUSE: begin
                     w_state = S_RUN;
                  end
                  default: begin
                  end
               endcase
            end
            c_OP_STOP: begin
               if (r_state == S_RUN) begin
                  w_state = S_PAUSE;
                  w_presc = w_tick ? '0 : r_presc;
               end
            end
            c_OP_CLEAR: begin
               w_tens        = r_preset[7:4];
               w_units       = r_preset[3:0];
               w_presc       = '0;
               w_state       = S_IDLE;
               w_reload_pend = 1'b0;
            end
            c_OP_SETTG: begin
               if (is_bcd(cmd_data)) begin
                  w_target = cmd_data;
               end else begin
                  w_err = 1'b1;
               end
            end
            default: begin
               w_err = 1'b1;
            end
         endcase
      end else if (w_tick) begin
         w_tens        = w_tick_q[7:4];
         w_units       = w_tick_q[3:0];
         w_reload_pend = 1'b0;
         if (w_tick_q == r_target) begin
            w_done = 1'b1;
            if (auto_reload) begin
               w_reload_pend = 1'b1;
            end else begin
               w_state = S_DONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         r_state       <= S_IDLE;
         r_tens        <= 4'd0;
         r_units       <= 4'd0;
         r_preset      <= 8'h00;
         r_target      <= 8'h99;
         r_presc       <= '0;
         r_ready       <= 1'b1;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_reload_pend <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_tens        <= w_tens;
         r_units       <= w_units;
         r_preset      <= w_preset;
         r_target      <= w_target;
         r_presc       <= w_presc;
         r_ready       <= w_ready;
         r_done        <= w_done;
         r_err         <= w_err;
         r_reload_pend <= w_reload_pend;
      end
   end

   assign cmd_ready = r_ready;
   assign Q         = {r_tens, r_units};
   assign state_o   = r_state;
   assign busy      = (r_state == S_RUN);
   assign done      = r_done;
   assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timer_ctrl.sv
// ============================================================================
// Module   : tb_bcd_timer_ctrl
// Function : scoreboard bench for bcd_timer_ctrl with directed vectors
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_timer_ctrl;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_START = 3'd2;
   localparam logic [2:0] OP_STOP  = 3'd3;
   localparam logic [2:0] OP_CLEAR = 3'd4;
   localparam logic [2:0] OP_SETTG = 3'd5;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   logic       clk = 1'b0;
   logic       _rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       mode_down = 1'b0;
   logic       auto_reload = 1'b0;
   logic       cmd_ready;
   logic [7:0] Q;
   logic [1:0] state_o;
   logic       busy, done, err;

   bcd_timer_ctrl #(.PRESCALE(4)) dut (
      .clk(clk), ._rst(_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .mode_down(mode_down),
      .auto_reload(auto_reload), .Q(Q), .state_o(state_o), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0]  q;
      logic        dn;
      logic        er;
      logic [1:0]  st;
      logic [31:0] cy;
   } ev_t;

   ev_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] prev_q = 8'h00;

   task automatic expect_ev(input logic [7:0] q, input logic dn, input logic er,
                            input logic [1:0] st, input int cy);
      ev_t x;
      x.q  = q;
      x.dn = dn;
      x.er = er;
      x.st = st;
      x.cy = 32'(cy);
      exp_q.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Any visible output activity (Q change, done, err) is one scoreboard event.
   always @(negedge clk) begin
      ev_t x;
      if (!_rst) begin
         prev_q = Q;
      end else if (Q !== prev_q || done || err) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d actual q=%h done=%b err=%b state=%b required none",
                     cyc, Q, done, err, state_o);
         end else begin
            x = exp_q.pop_front();
            if (Q !== x.q || done !== x.dn || err !== x.er || state_o !== x.st || 32'(cyc) != x.cy) begin
               errors++;
               $display("FAIL event actual q=%h done=%b err=%b state=%b cyc=%0d required q=%h done=%b err=%b state=%b cyc=%0d",
                        Q, done, err, state_o, cyc, x.q, x.dn, x.er, x.st, x.cy);
            end
         end
         prev_q = Q;
      end
   end

   task automatic send(input logic [2:0] op, input logic [7:0] data, output int acc);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      while (!ok) begin
         if (n != 0) @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #1;
         n++;
         if (!ok && n > 20) begin
            errors++;
            $display("FAIL send_timeout actual ready=0 required ready=1 op=%0d", op);
            $fatal(1, "command never accepted");
         end
      end
      cmd_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, s, r;
      logic [7:0] seq1 [5];
      seq1 = '{8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_q", 32'(Q), 32'h00);
      check("rst_state", 32'(state_o), 32'(ST_IDLE));
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_done_err", 32'({done, err, busy}), 32'd0);
      #1 _rst = 1'b1;

      // 1: up count 07 -> 12, one-shot
      send(OP_LOAD, 8'h07, a);
      expect_ev(8'h07, 1'b0, 1'b0, ST_IDLE, a);
      send(OP_START, 8'h00, s);
      send(OP_SETTG, 8'h12, a);
      for (int k = 0; k < 5; k++)
         expect_ev(seq1[k], (k == 4), 1'b0, (k == 4) ? ST_DONE : ST_RUN, s + 4 * (k + 1));
      wait_to(s + 24);
      check("t1_hold_q", 32'(Q), 32'h12);
      check("t1_state", 32'(state_o), 32'(ST_DONE));

      // 2: down count with borrow wrap 01 -> 00 -> 99 -> 98
      send(OP_LOAD, 8'h01, a);
      expect_ev(8'h01, 1'b0, 1'b0, ST_IDLE, a);
      mode_down = 1'b1;
      send(OP_SETTG, 8'h98, a);
      send(OP_START, 8'h00, s);
      expect_ev(8'h00, 1'b0, 1'b0, ST_RUN, s + 4);
      expect_ev(8'h99, 1'b0, 1'b0, ST_RUN, s + 8);
      expect_ev(8'h98, 1'b1, 1'b0, ST_DONE, s + 12);
      wait_to(s + 14);
      check("t2_state", 32'(state_o), 32'(ST_DONE));

      // 3: auto-reload 05,06,05,06
      send(OP_LOAD, 8'h05, a);
      expect_ev(8'h05, 1'b0, 1'b0, ST_IDLE, a);
      mode_down   = 1'b0;
      auto_reload = 1'b1;
      send(OP_SETTG, 8'h06, a);
      send(OP_START, 8'h00, s);
      expect_ev(8'h06, 1'b1, 1'b0, ST_RUN, s + 4);
      expect_ev(8'h05, 1'b0, 1'b0, ST_RUN, s + 8);
      expect_ev(8'h06, 1'b1, 1'b0, ST_RUN, s + 12);
      expect_ev(8'h05, 1'b0, 1'b0, ST_RUN, s + 16);
      wait_to(s + 17);
      send(OP_CLEAR, 8'h00, a);
      auto_reload = 1'b0;
      check("t3_clear_state", 32'(state_o), 32'(ST_IDLE));

      // 4: pause with presc=2 frozen, resume ticks after 2 clk; 6: CLEAR in tick cycle
      send(OP_SETTG, 8'h50, a);
      send(OP_START, 8'h00, s);
      wait_to(s + 2);
      send(OP_STOP, 8'h00, a);
      check("t4_stop_cycle", 32'(a - s), 32'd3);
      repeat (20) @(negedge clk);
      check("t4_pause_q", 32'(Q), 32'h05);
      check("t4_pause_state", 32'(state_o), 32'(ST_PAUSE));
      send(OP_START, 8'h00, r);
      expect_ev(8'h06, 1'b0, 1'b0, ST_RUN, r + 2);
      expect_ev(8'h07, 1'b0, 1'b0, ST_RUN, r + 6);
      wait_to(r + 9);
      send(OP_CLEAR, 8'h00, a);
      expect_ev(8'h05, 1'b0, 1'b0, ST_IDLE, r + 10);
      @(negedge clk);
      check("t6_clear_state", 32'(state_o), 32'(ST_IDLE));

      // 5: error pulses, then back-to-back handshake
      send(OP_LOAD, 8'h3A, a);
      expect_ev(8'h05, 1'b0, 1'b1, ST_IDLE, a);
      send(3'd7, 8'h00, a);
      expect_ev(8'h05, 1'b0, 1'b1, ST_IDLE, a);
      send(OP_SETTG, 8'hA0, a);
      expect_ev(8'h05, 1'b0, 1'b1, ST_IDLE, a);
      repeat (2) @(negedge clk);
      check("t5_err_q", 32'(Q), 32'h05);
      cmd_op    = OP_NOP;
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("t5_b2b_ready", 32'(cmd_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;

      // 6: asynchronous reset mid-RUN, target returns to 99
      send(OP_START, 8'h00, s);
      expect_ev(8'h06, 1'b0, 1'b0, ST_RUN, s + 4);
      wait_to(s + 5);
      @(negedge clk);
      #2 _rst = 1'b0;
      #1;
      check("rst_mid_q", 32'(Q), 32'h00);
      check("rst_mid_state", 32'(state_o), 32'(ST_IDLE));
      check("rst_mid_ready", 32'(cmd_ready), 32'd1);
      check("rst_mid_flags", 32'({done, err, busy}), 32'd0);
      repeat (2) @(negedge clk);
      #1 _rst = 1'b1;
      send(OP_LOAD, 8'h98, a);
      expect_ev(8'h98, 1'b0, 1'b0, ST_IDLE, a);
      send(OP_START, 8'h00, s);
      expect_ev(8'h99, 1'b1, 1'b0, ST_DONE, s + 4);
      wait_to(s + 6);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
